// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Contents: FSM state encoding, grant-owner codes, latency ceiling.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Largest latency the 4-bit counter can express.
    localparam int MAX_LAT = 15;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// rtl/mem_arb_lat_cnt.sv - loadable 4-bit down-counter timing the memory read latency
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   done      : high while the count is on its last step (next dec reaches zero)
module mem_arb_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Flag the final step so the owner can act on the same edge that takes
    // the count to zero; a load of 1 therefore gives exactly one WAIT cycle.
    assign done = (count == 4'd1);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for one fixed-latency memory port
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr                   : fetch request (read-only), held until if_ack
//   if_rdata/if_ack                  : fetch read data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata        : load/store request, held until d_ack
//   d_rdata/d_ack                    : load data (unchanged by stores), completion pulse
//   m_en/m_we/m_addr/m_wdata/m_rdata : memory port; m_rdata valid MEM_LAT cycles after m_en
//   busy                             : high whenever the FSM is not in IDLE
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates grants on simultaneous
// requests; otherwise data always wins a tie.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    import mem_arb_pkg::*;

    // Out-of-range latencies are pinned to what the counter can represent.
    localparam int LAT_CLAMP = (MEM_LAT < 1) ? 1 :
                               ((MEM_LAT > MAX_LAT) ? MAX_LAT : MEM_LAT);
    localparam logic [3:0] LAT_LOAD = 4'(LAT_CLAMP);

    state_t state;
    logic   owner;
    logic   grant_owner;
    logic   cnt_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic   rr_last;
`endif

    always_comb begin
        grant_owner = d_req ? OWN_DATA : OWN_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie, the requester that did not win last time gets the port.
        if (if_req && d_req) begin
            grant_owner = (rr_last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end
`endif
    end

    mem_arb_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE),
        .load_val (LAT_LOAD),
        .dec      (state == WAIT),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_FETCH;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last  <= OWN_FETCH;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            m_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        // Latch straight into the memory-port registers so they
                        // are valid during ISSUE and hold until the next ISSUE.
                        owner <= grant_owner;
                        m_en  <= 1'b1;
                        if (grant_owner == OWN_DATA) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_last <= grant_owner;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt_done) begin
                        // Stores complete without touching d_rdata.
                        if (!m_we) begin
                            if (owner == OWN_DATA) begin
                                d_rdata <= m_rdata;
                            end else begin
                                if_rdata <= m_rdata;
                            end
                        end
                        if (owner == OWN_DATA) begin
                            d_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (MEM_LAT 1 and 4 instances)
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int vectors     = 0;
    int miscompares = 0;

    int lat [2];

    logic        if_req [2];
    logic        d_req  [2];
    logic        d_we   [2];
    logic [31:0] if_addr [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] m_rdata [2];

    logic [31:0] if_rdata_w [2];
    logic [31:0] d_rdata_w  [2];
    logic [31:0] m_addr_w   [2];
    logic [31:0] m_wdata_w  [2];
    logic        if_ack_w   [2];
    logic        d_ack_w    [2];
    logic        m_en_w     [2];
    logic        m_we_w     [2];
    logic        busy_w     [2];

    // Transaction-level model state
    bit          seen_rst = 1'b0;
    bit          act   [2];
    int          t0    [2];
    logic        own   [2];
    logic        twe   [2];
    logic [31:0] taddr [2];
    logic [31:0] twdata[2];
    logic [31:0] trd   [2];
    logic        rrl   [2];
    logic        e_we  [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_wdata[2];
    logic [31:0] e_ifrd [2];
    logic [31:0] e_drd  [2];
    logic [31:0] emem [2][256];
    bit          en_e;
    bit          ack_e;

    // Memory responder state
    logic [31:0] mem [2][256];
    int          rd_cyc [2];
    logic [31:0] rd_val [2];

    int gord [8];
    int gcyc [8];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata_w[0]), .if_ack(if_ack_w[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata_w[0]), .d_ack(d_ack_w[0]),
        .m_en(m_en_w[0]), .m_we(m_we_w[0]), .m_addr(m_addr_w[0]), .m_wdata(m_wdata_w[0]),
        .m_rdata(m_rdata[0]), .busy(busy_w[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata_w[1]), .if_ack(if_ack_w[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata_w[1]), .d_ack(d_ack_w[1]),
        .m_en(m_en_w[1]), .m_we(m_we_w[1]), .m_addr(m_addr_w[1]), .m_wdata(m_wdata_w[1]),
        .m_rdata(m_rdata[1]), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", name, k, cyc, got, exp);
        end
    endtask

    // Per-cycle compare, memory responder and model advance.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            en_e  = act[k] && (cyc == t0[k] + 1);
            ack_e = act[k] && (cyc == t0[k] + 2 + lat[k]);
            if (seen_rst) begin
                if (en_e) begin
                    e_we[k]    = twe[k];
                    e_addr[k]  = taddr[k];
                    e_wdata[k] = twdata[k];
                end
                if (ack_e && !twe[k]) begin
                    if (own[k]) e_drd[k] = trd[k];
                    else        e_ifrd[k] = trd[k];
                end
                chk("busy",     k, 32'(busy_w[k]),   32'(act[k] && (cyc > t0[k])));
                chk("m_en",     k, 32'(m_en_w[k]),   32'(en_e));
                chk("m_we",     k, 32'(m_we_w[k]),   32'(e_we[k]));
                chk("m_addr",   k, m_addr_w[k],      e_addr[k]);
                chk("m_wdata",  k, m_wdata_w[k],     e_wdata[k]);
                chk("if_ack",   k, 32'(if_ack_w[k]), 32'(ack_e && !own[k]));
                chk("d_ack",    k, 32'(d_ack_w[k]),  32'(ack_e && own[k]));
                chk("if_rdata", k, if_rdata_w[k],    e_ifrd[k]);
                chk("d_rdata",  k, d_rdata_w[k],     e_drd[k]);
            end

            if (m_en_w[k] === 1'b1) begin
                if (m_we_w[k] === 1'b1) mem[k][m_addr_w[k][7:0]] = m_wdata_w[k];
                rd_val[k] = mem[k][m_addr_w[k][7:0]];
                rd_cyc[k] = cyc + lat[k];
            end
            m_rdata[k] = (cyc == rd_cyc[k]) ? rd_val[k] : $urandom;

            if (rst) begin
                act[k]     = 1'b0;
                e_we[k]    = 1'b0;
                e_addr[k]  = 32'h0;
                e_wdata[k] = 32'h0;
                e_ifrd[k]  = 32'h0;
                e_drd[k]   = 32'h0;
                rrl[k]     = 1'b0;
            end else if (ack_e) begin
                act[k] = 1'b0;
            end else if (!act[k] && (if_req[k] || d_req[k])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (if_req[k] && d_req[k]) own[k] = (rrl[k] == 1'b0) ? 1'b1 : 1'b0;
                else if (d_req[k])         own[k] = 1'b1;
                else                       own[k] = 1'b0;
                rrl[k] = own[k];
`else
                if (d_req[k]) own[k] = 1'b1;
                else          own[k] = 1'b0;
`endif
                twe[k]    = own[k] ? d_we[k] : 1'b0;
                taddr[k]  = own[k] ? d_addr[k] : if_addr[k];
                twdata[k] = own[k] ? d_wdata[k] : 32'h0;
                if (twe[k]) emem[k][taddr[k][7:0]] = twdata[k];
                trd[k] = emem[k][taddr[k][7:0]];
                t0[k]  = cyc;
                act[k] = 1'b1;
            end
        end
        if (rst) seen_rst = 1'b1;
    end

    task automatic do_req(input int k, input bit isd, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, output int dt_en, output int dt_ack);
        int t;
        @(posedge clk);
        #2;
        if (isd) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = a;
        end
        t = cyc;
        dt_en  = -1;
        dt_ack = -1;
        for (int i = 0; i < 40 && dt_ack < 0; i++) begin
            @(negedge clk);
            if (m_en_w[k] === 1'b1 && dt_en < 0) dt_en = cyc - t;
            if ((isd ? d_ack_w[k] : if_ack_w[k]) === 1'b1) dt_ack = cyc - t;
        end
        @(posedge clk);
        #2;
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        d_we[k]   = 1'b0;
    endtask

    // Both requesters raise together; with keep they re-request after each ack.
    task automatic run_both(input int k, input int n, input bit keep);
        int  got;
        bit  drop_d, drop_f;
        for (int i = 0; i < 8; i++) begin gord[i] = 2; gcyc[i] = -100; end
        @(posedge clk);
        #2;
        if_req[k] = 1'b1; if_addr[k] = 32'h20;
        d_req[k]  = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h80;
        got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            drop_d = 1'b0;
            drop_f = 1'b0;
            if (d_ack_w[k] === 1'b1 && got < 8) begin
                gord[got] = 1; gcyc[got] = cyc; got++; drop_d = !keep;
            end
            if (if_ack_w[k] === 1'b1 && got < 8) begin
                gord[got] = 0; gcyc[got] = cyc; got++; drop_f = !keep;
            end
            @(posedge clk);
            #2;
            if (drop_d) d_req[k] = 1'b0;
            if (drop_f) if_req[k] = 1'b0;
        end
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dt_en;
        int dt_ack;
        int nack;
        int exp_ord [4];

        lat[0] = 1;
        lat[1] = 4;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            if_addr[k] = 32'h0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0; m_rdata[k] = 32'h0;
            act[k] = 1'b0; t0[k] = 0; own[k] = 1'b0; twe[k] = 1'b0; rrl[k] = 1'b0;
            taddr[k] = 32'h0; twdata[k] = 32'h0; trd[k] = 32'h0;
            e_we[k] = 1'b0; e_addr[k] = 32'h0; e_wdata[k] = 32'h0; e_ifrd[k] = 32'h0; e_drd[k] = 32'h0;
            rd_cyc[k] = -1; rd_val[k] = 32'h0;
            for (int a = 0; a < 256; a++) begin
                mem[k][a]  = mem_default(32'(a));
                emem[k][a] = mem_default(32'(a));
            end
        end
        mem[0][8'h10] = 32'hDEADBEEF; emem[0][8'h10] = 32'hDEADBEEF;
        mem[1][8'h30] = 32'hCAFEF00D; emem[1][8'h30] = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",     k, 32'(busy_w[k]), 32'h0);
            chk("rst_m_en",     k, 32'(m_en_w[k]), 32'h0);
            chk("rst_m_addr",   k, m_addr_w[k],    32'h0);
            chk("rst_if_rdata", k, if_rdata_w[k],  32'h0);
            chk("rst_d_rdata",  k, d_rdata_w[k],   32'h0);
        end

        // Fetch at MEM_LAT=1
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, dt_en, dt_ack);
        chk("t1_en_lat",   0, dt_en,         32'd1);
        chk("t1_ack_lat",  0, dt_ack,        32'd3);
        chk("t1_if_rdata", 0, if_rdata_w[0], 32'hDEADBEEF);
        chk("t1_d_rdata",  0, d_rdata_w[0],  32'h0);

        // Load then store then load back
        do_req(0, 1'b1, 1'b0, 32'h80, 32'h0, dt_en, dt_ack);
        chk("t2_ack_lat", 0, dt_ack,       32'd3);
        chk("t2_d_rdata", 0, d_rdata_w[0], 32'hA5A50080);

        do_req(0, 1'b1, 1'b1, 32'h40, 32'h12345678, dt_en, dt_ack);
        chk("t3_en_lat",  0, dt_en,          32'd1);
        chk("t3_ack_lat", 0, dt_ack,         32'd3);
        chk("t3_d_rdata", 0, d_rdata_w[0],   32'hA5A50080);
        chk("t3_m_we",    0, 32'(m_we_w[0]), 32'd1);
        chk("t3_m_addr",  0, m_addr_w[0],    32'h40);
        chk("t3_m_wdata", 0, m_wdata_w[0],   32'h12345678);

        do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, dt_en, dt_ack);
        chk("t4_d_rdata", 0, d_rdata_w[0], 32'h12345678);

        // Simultaneous requests after a fresh reset: data first, then fetch
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        run_both(0, 2, 1'b0);
        chk("t5_first",    0, gord[0],             32'd1);
        chk("t5_second",   0, gord[1],             32'd0);
        chk("t5_spacing",  0, gcyc[1] - gcyc[0],   32'd4);
        chk("t5_d_rdata",  0, d_rdata_w[0],        32'hA5A50080);
        chk("t5_if_rdata", 0, if_rdata_w[0],       32'hA5A50020);

        // Both held for four grants
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_ord = '{1, 0, 1, 0};
`else
        exp_ord = '{1, 1, 1, 1};
`endif
        run_both(0, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t6_order", 0, gord[i], exp_ord[i]);
            if (i > 0) chk("t6_period", 0, gcyc[i] - gcyc[i-1], 32'd4);
        end

        // Fetch at MEM_LAT=4 with garbage on m_rdata outside the data cycle
        do_req(1, 1'b0, 1'b0, 32'h30, 32'h0, dt_en, dt_ack);
        chk("t7_en_lat",   1, dt_en,         32'd1);
        chk("t7_ack_lat",  1, dt_ack,        32'd6);
        chk("t7_if_rdata", 1, if_rdata_w[1], 32'hCAFEF00D);

        // Reset during WAIT aborts without an ack
        @(posedge clk); #2; if_req[1] = 1'b1; if_addr[1] = 32'h50;
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2; rst = 1'b1; if_req[1] = 1'b0;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("t8_busy", 1, 32'(busy_w[1]), 32'h0);
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_ack_w[1] === 1'b1 || d_ack_w[1] === 1'b1) nack++;
        end
        chk("t8_no_ack",   1, nack,          32'd0);
        chk("t8_if_rdata", 1, if_rdata_w[1], 32'h0);
        do_req(1, 1'b0, 1'b0, 32'h10, 32'h0, dt_en, dt_ack);
        chk("t8_ack_lat",  1, dt_ack,        32'd6);
        chk("t8_rdata",    1, if_rdata_w[1], 32'hA5A50010);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, fixed-latency memory port between two requesters: the instruction-fetch path (read-only) and the load/store data path (read/write).
- Sits between the core's fetch/data logic and the single memory macro.
- Sequences one transaction at a time through a small FSM and returns the read data with a one-cycle acknowledge pulse.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LAT, 1, cycles from the m_en cycle to m_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetch read data; valid when if_ack is high.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid when d_ack is high.
- d_ack  out  1  one-cycle completion pulse for data.
- m_en  out  1  memory access strobe, one cycle per transaction.
- m_we  out  1  memory write enable; qualified by m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the m_en cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE; if_ack = d_ack = m_en = m_we = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; latency counter = 0; rr_last = FETCH.
- States:
  - IDLE: samples requests. On any request, latches the winner's addr/we/wdata and the grant owner, then goes to ISSUE.
  - ISSUE: m_en = 1 for exactly one cycle; m_we = latched we (always 0 for fetch). Counter loads MEM_LAT. Next state is WAIT.
  - WAIT: counter decrements each cycle. On the cycle the counter reaches 0 (exactly MEM_LAT cycles after ISSUE), m_rdata is captured into the owner's rdata register. Next state is RESP.
  - RESP: the owner's ack is high for one cycle. Next state is IDLE.
- Latency: a request first seen in IDLE at cycle T produces m_en at T+1 and ack at T+2+MEM_LAT. Stores use the same latency. Store ack carries no data, and d_rdata holds its previous value.
- Throughput: one transaction per MEM_LAT+3 cycles.
- Default arbitration: fixed priority, data over fetch. A simultaneous if_req and d_req in IDLE grants data. The fetch request stays pending and wins the next IDLE.
- Handshake rules:
  - A requester must drop req in the cycle after its ack, unless it is issuing a new request.
  - A req that is still high in the IDLE following RESP is a new transaction.
  - The non-owner's rdata and ack never change during another owner's transaction.
- m_addr, m_wdata and m_we hold their latched values from ISSUE until the next ISSUE. m_en is the only strobe.
- Reset mid-transaction: the FSM returns to IDLE next cycle. No ack is emitted, and any later m_rdata is ignored.
- Requests arriving during ISSUE/WAIT/RESP are not sampled until IDLE; no queueing.
- Counter width: 4 bits, with no wrap. MEM_LAT = 1 gives a single WAIT cycle.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the requester that is not rr_last. rr_last updates to the owner on every grant. After reset, the first tie goes to data (rr_last = FETCH).
- Undefined: fixed data-over-fetch priority; rr_last is not implemented.
- Single requests behave identically in both builds.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - owner constants OWN_FETCH = 1'b0, OWN_DATA = 1'b1.
  - MAX_LAT = 15.
- One sub-module: mem_arb_lat_cnt, a loadable 4-bit down-counter with a done flag.
- Arbitration and the FSM stay in mem_arbiter.

Test Plan:
- MEM_LAT = 1; if_req with if_addr = 0x10; memory returns 0xDEADBEEF -> m_en one cycle after the request, if_ack exactly 3 cycles after the request, if_rdata = 0xDEADBEEF, d_ack stays 0.
- Store: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0x12345678 -> one m_en with m_we = 1, m_addr = 0x40, m_wdata = 0x12345678; d_ack 3 cycles after the request; d_rdata unchanged.
- Simultaneous if_req and d_req (load at 0x80) held high -> data served first. Fetch m_en follows data RESP by 2 cycles; acks arrive in the order data, then fetch.
- MEM_LAT = 4; fetch request -> if_ack at T+6; m_rdata captured only at T+5, and garbage on m_rdata at other cycles has no effect.
- rst asserted during WAIT -> next cycle state is IDLE, busy = 0; no ack for the aborted request; a subsequent request completes normally.
- With MEM_ARB_ROUND_ROBIN_EN, both requests held continuously for 4 grants -> grant order data, fetch, data, fetch. Without the macro -> data every time while d_req is held.
